// File: rtl/game_input_if.sv
// Button/frame signal bundle between the game input controller and its host.
// The master drives the raw inputs; the slave (controller) returns the conditioned state.
interface game_input_if #(
  parameter int unsigned NUM_BTNS = 2,
  parameter int unsigned FRAME_W  = 16
);
  logic [NUM_BTNS-1:0] btn_raw;
  logic                screen_end;
  logic [NUM_BTNS-1:0] btn_ack;
  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] btn_pressed;
  logic                frame_tick;
  logic [FRAME_W-1:0]  frame_count;

  modport master (
    output btn_raw, screen_end, btn_ack,
    input  btn_level, btn_pressed, frame_tick, frame_count
  );

  modport slave (
    input  btn_raw, screen_end, btn_ack,
    output btn_level, btn_pressed, frame_tick, frame_count
  );
endinterface

// File: rtl/game_input_ctrl.sv
// Button synchronizer/debouncer with sticky press latches, plus frame-start detection
// and a free-running frame counter driven by the VGA end-of-frame level.
module game_input_ctrl #(
  parameter int unsigned NUM_BTNS        = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned FRAME_W         = 16,
  parameter int unsigned AUTO_CLEAR      = 0
) (
  input logic         clock,
  input logic         reset,
  game_input_if.slave bus
);
  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam bit              AutoClr = (AUTO_CLEAR != 0);

  logic [NUM_BTNS-1:0] sync1_q, sync2_q;
  logic [NUM_BTNS-1:0] level_q, level_d;
  logic [NUM_BTNS-1:0] pressed_q, pressed_d;
  logic [NUM_BTNS-1:0] set_vec, clr_vec;
  logic [CntW-1:0]     cnt_q [NUM_BTNS];
  logic [CntW-1:0]     cnt_d [NUM_BTNS];
  logic                se_q, tick_q;
  logic                frame_start;
  logic [FRAME_W-1:0]  frame_q, frame_d;

  always_comb begin
    frame_start = bus.screen_end & ~se_q;
    frame_d     = frame_q + FRAME_W'(frame_start);

    // Counter only runs while sync disagrees with the level; any agreement restarts it.
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      level_d[i] = level_q[i];
      cnt_d[i]   = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end

    // A new rising edge beats any clear landing on the same edge.
    set_vec   = level_d & ~level_q;
    clr_vec   = bus.btn_ack | {NUM_BTNS{AutoClr & frame_start}};
    pressed_d = set_vec | (pressed_q & ~clr_vec);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      pressed_q <= '0;
      cnt_q     <= '{default: '0};
      se_q      <= 1'b0;
      tick_q    <= 1'b0;
      frame_q   <= '0;
    end else begin
      sync1_q   <= bus.btn_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      pressed_q <= pressed_d;
      cnt_q     <= cnt_d;
      se_q      <= bus.screen_end;
      tick_q    <= frame_start;
      frame_q   <= frame_d;
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_pressed = pressed_q;
  assign bus.frame_tick  = tick_q;
  assign bus.frame_count = frame_q;
endmodule

// File: tb/tb_game_input_ctrl.sv
// Directed bench for game_input_ctrl: one instance per AUTO_CLEAR setting, shared stimulus.
module tb_game_input_ctrl;
  localparam int unsigned NB = 2;
  localparam int unsigned DB = 4;
  localparam int unsigned FW = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] raw   = '0;
  logic [1:0] ack   = '0;
  logic       se    = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_cnt  = '0;
  logic       exp_tick = 1'b0;
  logic       prev_se  = 1'b0;

  typedef struct {
    logic [1:0] raw;
    logic [1:0] ack;
    logic       se;
    logic [1:0] lvl;
    logic [1:0] p0;
    logic [1:0] p1;
  } vec_t;
  vec_t tbl[$];

  game_input_if #(.NUM_BTNS(NB), .FRAME_W(FW)) bus0 ();
  game_input_if #(.NUM_BTNS(NB), .FRAME_W(FW)) bus1 ();

  assign bus0.btn_raw    = raw;
  assign bus0.btn_ack    = ack;
  assign bus0.screen_end = se;
  assign bus1.btn_raw    = raw;
  assign bus1.btn_ack    = ack;
  assign bus1.screen_end = se;

  game_input_ctrl #(
    .NUM_BTNS(NB), .DEBOUNCE_CYCLES(DB), .FRAME_W(FW), .AUTO_CLEAR(0)
  ) dut0 (
    .clock(clock), .reset(reset), .bus(bus0.slave)
  );

  game_input_ctrl #(
    .NUM_BTNS(NB), .DEBOUNCE_CYCLES(DB), .FRAME_W(FW), .AUTO_CLEAR(1)
  ) dut1 (
    .clock(clock), .reset(reset), .bus(bus1.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] lvl, input logic [1:0] p0,
                           input logic [1:0] p1);
    chk({tag, " level_ac0"}, 32'(bus0.btn_level), 32'(lvl));
    chk({tag, " level_ac1"}, 32'(bus1.btn_level), 32'(lvl));
    chk({tag, " pressed_ac0"}, 32'(bus0.btn_pressed), 32'(p0));
    chk({tag, " pressed_ac1"}, 32'(bus1.btn_pressed), 32'(p1));
    chk({tag, " tick_ac0"}, 32'(bus0.frame_tick), 32'(exp_tick));
    chk({tag, " tick_ac1"}, 32'(bus1.frame_tick), 32'(exp_tick));
    chk({tag, " count_ac0"}, 32'(bus0.frame_count), 32'(exp_cnt));
    chk({tag, " count_ac1"}, 32'(bus1.frame_count), 32'(exp_cnt));
  endtask

  // One rising edge, then advance the frame model from the inputs that edge saw.
  task automatic adv();
    @(posedge clock);
    #1;
    exp_tick = se && !prev_se;
    if (exp_tick) exp_cnt = exp_cnt + 8'd1;
    prev_se = se;
  endtask

  task automatic do_reset(input string tag);
    raw = '0;
    ack = '0;
    se  = 1'b0;
    #2 reset = 1'b1;
    #1;
    exp_cnt  = '0;
    exp_tick = 1'b0;
    prev_se  = 1'b0;
    check_all(tag, 2'b00, 2'b00, 2'b00);
    adv();
    #3 reset = 1'b0;
  endtask

  function automatic void add(input logic [1:0] r, input logic [1:0] a, input logic s,
                              input logic [1:0] l, input logic [1:0] q0,
                              input logic [1:0] q1);
    vec_t v;
    v.raw = r;
    v.ack = a;
    v.se  = s;
    v.lvl = l;
    v.p0  = q0;
    v.p1  = q1;
    tbl.push_back(v);
  endfunction

  initial begin
    // Clean press on ch0, ack while held, then release.
    for (int e = 1; e <= 5; e++) add(2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    for (int e = 6; e <= 8; e++) add(2'b01, 2'b00, 1'b0, 2'b01, 2'b01, 2'b01);
    add(2'b01, 2'b01, 1'b0, 2'b01, 2'b00, 2'b00);
    for (int e = 10; e <= 12; e++) add(2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00);
    for (int e = 1; e <= 5; e++) add(2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00);
    add(2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    // Ack and frame start collide with the rising edge; release keeps the latch.
    for (int e = 1; e <= 5; e++) add(2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    add(2'b01, 2'b01, 1'b1, 2'b01, 2'b01, 2'b01);
    add(2'b01, 2'b00, 1'b0, 2'b01, 2'b01, 2'b01);
    for (int e = 1; e <= 5; e++) add(2'b00, 2'b00, 1'b0, 2'b01, 2'b01, 2'b01);
    add(2'b00, 2'b00, 1'b0, 2'b00, 2'b01, 2'b01);
    // Press ch1, then frame start with no new edge: only AUTO_CLEAR=1 clears.
    for (int e = 1; e <= 5; e++) add(2'b10, 2'b00, 1'b0, 2'b00, 2'b01, 2'b01);
    add(2'b10, 2'b00, 1'b0, 2'b10, 2'b11, 2'b11);
    add(2'b10, 2'b00, 1'b1, 2'b10, 2'b11, 2'b00);
    add(2'b10, 2'b00, 1'b0, 2'b10, 2'b11, 2'b00);
    for (int e = 1; e <= 5; e++) add(2'b00, 2'b00, 1'b0, 2'b10, 2'b11, 2'b00);
    add(2'b00, 2'b00, 1'b0, 2'b00, 2'b11, 2'b00);
    add(2'b00, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00);

    do_reset("reset_initial");
    adv();
    check_all("post_reset", 2'b00, 2'b00, 2'b00);

    // Bounce on ch1: never stable long enough to change the level.
    for (int i = 0; i < 24; i++) begin
      raw = {((i / 2) % 2) == 0, 1'b0};
      adv();
      check_all($sformatf("bounce%0d", i), 2'b00, 2'b00, 2'b00);
    end
    raw = '0;
    for (int i = 0; i < 8; i++) begin
      adv();
      check_all($sformatf("bounce_tail%0d", i), 2'b00, 2'b00, 2'b00);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      raw = tbl[i].raw;
      ack = tbl[i].ack;
      se  = tbl[i].se;
      adv();
      check_all($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].p0, tbl[i].p1);
    end
    raw = '0;
    ack = '0;
    se  = 1'b0;
    adv();

    // screen_end held for 5 cycles gives a single tick and a single increment.
    se = 1'b1;
    for (int i = 0; i < 5; i++) begin
      adv();
      check_all($sformatf("se_hold%0d", i), 2'b00, 2'b00, 2'b00);
    end
    se = 1'b0;
    adv();
    check_all("se_hold_end", 2'b00, 2'b00, 2'b00);

    // 256 frame starts from reset wrap the counter back to zero.
    do_reset("reset_wrap");
    for (int i = 0; i < 256; i++) begin
      se = 1'b1;
      adv();
      check_all($sformatf("frame%0d", i), 2'b00, 2'b00, 2'b00);
      se = 1'b0;
      adv();
    end
    chk("wrap_to_zero", 32'(bus0.frame_count), 32'h0);

    // Build level=11, pressed=01, count=0x37, then reset asynchronously.
    do_reset("reset_pre_midop");
    for (int i = 0; i < 55; i++) begin
      se = 1'b1;
      adv();
      se = 1'b0;
      adv();
    end
    chk("count_37", 32'(bus0.frame_count), 32'h37);
    raw = 2'b11;
    for (int e = 1; e <= 6; e++) begin
      adv();
      if (e == 6) check_all("both_press", 2'b11, 2'b11, 2'b11);
      else check_all($sformatf("both_wait%0d", e), 2'b00, 2'b00, 2'b00);
    end
    ack = 2'b10;
    adv();
    check_all("ack_ch1", 2'b11, 2'b01, 2'b01);
    ack = 2'b00;
    #2 reset = 1'b1;
    #1;
    exp_cnt  = '0;
    exp_tick = 1'b0;
    prev_se  = 1'b0;
    check_all("async_reset", 2'b00, 2'b00, 2'b00);
    adv();
    check_all("reset_held", 2'b00, 2'b00, 2'b00);
    #3 reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      adv();
      if (e == 6) check_all("held_after_reset", 2'b11, 2'b11, 2'b11);
      else check_all($sformatf("held_wait%0d", e), 2'b00, 2'b00, 2'b00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
